// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : Splits a 32-bit MEM-stage load/store into two 16-bit SRAM phases
//            (low then high half-word), each held for WAIT_CYCLES+1 cycles.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_en,
    input  logic        MEM_W_en,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        freeze,
    output logic [17:0] SRAM_ADDR,
    output logic [15:0] SRAM_DQ_out,
    output logic        SRAM_DQ_oe,
    input  logic [15:0] SRAM_DQ_in,
    output logic        SRAM_WE_N
);

    localparam logic [3:0] c_WAIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic        r_write;
    logic [16:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_last_half;
    logic        w_req;
    logic        w_in_phase;
    logic        w_phase_end;
    logic        w_half;
    logic        w_unused;

    assign w_unused = ^{address[31:19], address[1:0]};

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_req       = MEM_R_en | MEM_W_en;
        w_in_phase  = (r_state == S_LOW) || (r_state == S_HIGH);
        w_phase_end = w_in_phase && (r_cnt == c_WAIT);
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_state_nxt = S_LOW;
                    w_cnt_nxt   = 4'd0;
                end
            end
            S_LOW: begin
                if (w_phase_end) begin
                    w_state_nxt = S_HIGH;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            S_HIGH: begin
                if (w_phase_end) begin
                    w_state_nxt = S_DONE;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_write     <= 1'b0;
            r_addr      <= 17'd0;
            r_wdata     <= 32'd0;
            r_last_half <= 1'b0;
            rdata       <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            // Write wins when both requests are raised together
            if (r_state == S_IDLE && w_req) begin
                r_write <= MEM_W_en;
                r_addr  <= address[18:2];
                r_wdata <= wdata;
            end
            if (r_state == S_HIGH) begin
                r_last_half <= 1'b1;
            end
            if (!r_write && w_phase_end) begin
                if (r_state == S_LOW) begin
                    rdata[15:0] <= SRAM_DQ_in;
                end else begin
                    rdata[31:16] <= SRAM_DQ_in;
                end
            end
        end
    end

    // Outside the two phases the address bus keeps the last half-word driven
    always_comb begin
        w_half = r_last_half;
        if (r_state == S_LOW) begin
            w_half = 1'b0;
        end else if (r_state == S_HIGH) begin
            w_half = 1'b1;
        end
    end

    assign SRAM_ADDR   = {r_addr, w_half};
    assign ready       = (r_state == S_DONE);
    assign freeze      = w_req & ~ready;
    assign SRAM_DQ_oe  = r_write & w_in_phase;
    // Strobe released on the last cycle of each phase so data is held past WE_N rise
    assign SRAM_WE_N   = ~(SRAM_DQ_oe && (r_cnt < c_WAIT || c_WAIT == 4'd0));
    assign SRAM_DQ_out = !SRAM_DQ_oe         ? 16'h0000 :
                         (r_state == S_HIGH) ? r_wdata[31:16] : r_wdata[15:0];

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_ctrl
// Purpose  : Randomized self-checking bench for mem_access_ctrl against a
//            cycle-offset reference model and a behavioural SRAM.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_access_ctrl;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        r_en, w_en;
    logic [31:0] address, wdata, rdata;
    logic        ready, freeze;
    logic [17:0] sram_addr;
    logic [15:0] dq_out, dq_in;
    logic        dq_oe, we_n;

    logic        r_en0, w_en0;
    logic [31:0] address0, wdata0, rdata0;
    logic        ready0, freeze0;
    logic [17:0] sram_addr0;
    logic [15:0] dq_out0, dq_in0;
    logic        dq_oe0, we_n0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [15:0] sram_mem [int];
    logic [15:0] exp_mem  [int];
    logic [31:0] exp_rdata;
    logic [17:0] exp_last;

    always #5 clk = ~clk;

    mem_access_ctrl #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .MEM_R_en(r_en), .MEM_W_en(w_en),
        .address(address), .wdata(wdata), .rdata(rdata), .ready(ready),
        .freeze(freeze), .SRAM_ADDR(sram_addr), .SRAM_DQ_out(dq_out),
        .SRAM_DQ_oe(dq_oe), .SRAM_DQ_in(dq_in), .SRAM_WE_N(we_n)
    );

    mem_access_ctrl #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .MEM_R_en(r_en0), .MEM_W_en(w_en0),
        .address(address0), .wdata(wdata0), .rdata(rdata0), .ready(ready0),
        .freeze(freeze0), .SRAM_ADDR(sram_addr0), .SRAM_DQ_out(dq_out0),
        .SRAM_DQ_oe(dq_oe0), .SRAM_DQ_in(dq_in0), .SRAM_WE_N(we_n0)
    );

    function automatic logic [15:0] dflt(input logic [17:0] a);
        return a[15:0] ^ {a[17:16], 14'h1A5C} ^ 16'h7E31;
    endfunction

    function automatic logic [15:0] sram_rd(input logic [17:0] a);
        return sram_mem.exists(int'(a)) ? sram_mem[int'(a)] : dflt(a);
    endfunction

    function automatic logic [15:0] mem_expect(input logic [17:0] a);
        return exp_mem.exists(int'(a)) ? exp_mem[int'(a)] : dflt(a);
    endfunction

    // Behavioural asynchronous SRAMs
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!we_n && dq_oe) sram_mem[int'(sram_addr)] = dq_out;
        dq_in  = sram_rd(sram_addr);
        dq_in0 = dflt(sram_addr0);
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            r_en = 1'b0; w_en = 1'b0; address = $urandom; wdata = $urandom;
            #1;
            checks++;
            if (ready !== 1'b0 || freeze !== 1'b0 || we_n !== 1'b1 || dq_oe !== 1'b0 ||
                sram_addr !== exp_last || rdata !== exp_rdata) begin
                errors++;
                $display("FAIL idle rdy=%b frz=%b wen=%b oe=%b addr=%h rdata=%h exp addr=%h rdata=%h",
                         ready, freeze, we_n, dq_oe, sram_addr, rdata, exp_last, exp_rdata);
            end
        end
    endtask

    // mode: 0 hold request, 1 drop it, 2 scramble inputs after the sampling cycle
    task automatic do_access(input bit wr, input bit both, input logic [31:0] a,
                             input logic [31:0] wd, input int mode, output int lat);
        logic [17:0] a0, a1, exp_ad;
        logic [15:0] lo, hi;
        logic [31:0] old, exp_rd;
        bit lowph, highph, dn, exp_oe, exp_wen, exp_fr;
        int p, c0;
        a0 = {a[18:2], 1'b0}; a1 = {a[18:2], 1'b1};
        lo = mem_expect(a0);   hi = mem_expect(a1);
        old = exp_rdata;
        @(negedge clk);
        r_en = !wr || both; w_en = wr; address = a; wdata = wd;
        #1;
        c0 = cyc;
        checks++;
        if (ready !== 1'b0 || freeze !== 1'b1 || we_n !== 1'b1 || dq_oe !== 1'b0 ||
            sram_addr !== exp_last || rdata !== old) begin
            errors++;
            $display("FAIL sample_cycle rdy=%b frz=%b wen=%b oe=%b addr=%h rdata=%h exp addr=%h",
                     ready, freeze, we_n, dq_oe, sram_addr, rdata, exp_last);
        end
        for (int k = 1; k <= 2*W+3; k++) begin
            @(negedge clk);
            if (mode == 1) begin
                r_en = 1'b0; w_en = 1'b0;
            end else if (mode == 2) begin
                r_en = 1'($urandom); w_en = 1'($urandom); address = $urandom; wdata = $urandom;
            end
            #1;
            lowph  = (k <= W+1);
            highph = (k >= W+2) && (k <= 2*W+2);
            dn     = (k == 2*W+3);
            p      = lowph ? k-1 : k-W-2;
            exp_oe  = wr && (lowph || highph);
            exp_wen = !(exp_oe && p < W);
            exp_ad  = lowph ? a0 : a1;
            exp_fr  = (r_en | w_en) && !dn;
            exp_rd  = old;
            if (!wr && highph) exp_rd[15:0] = lo;
            if (!wr && dn)     exp_rd = {hi, lo};
            checks++;
            if (ready !== dn) begin
                errors++; $display("FAIL ready k=%0d got %b exp %b", k, ready, dn);
            end
            checks++;
            if (freeze !== exp_fr) begin
                errors++; $display("FAIL freeze k=%0d got %b exp %b", k, freeze, exp_fr);
            end
            checks++;
            if (we_n !== exp_wen || dq_oe !== exp_oe) begin
                errors++; $display("FAIL strobe k=%0d got wen=%b oe=%b exp wen=%b oe=%b",
                                   k, we_n, dq_oe, exp_wen, exp_oe);
            end
            checks++;
            if (sram_addr !== exp_ad) begin
                errors++; $display("FAIL sram_addr k=%0d got %h exp %h", k, sram_addr, exp_ad);
            end
            checks++;
            if (rdata !== exp_rd) begin
                errors++; $display("FAIL rdata k=%0d got %h exp %h", k, rdata, exp_rd);
            end
            if (exp_oe) begin
                checks++;
                if (dq_out !== (lowph ? wd[15:0] : wd[31:16])) begin
                    errors++; $display("FAIL dq_out k=%0d got %h exp %h", k, dq_out,
                                       lowph ? wd[15:0] : wd[31:16]);
                end
            end
        end
        lat = cyc - c0;
        if (wr) begin
            exp_mem[int'(a0)] = wd[15:0];
            exp_mem[int'(a1)] = wd[31:16];
        end else begin
            exp_rdata = {hi, lo};
        end
        exp_last = a1;
    endtask

    task automatic test_reset;
        rst = 1'b0; r_en = 1'b0; w_en = 1'b0; address = '0; wdata = '0;
        r_en0 = 1'b0; w_en0 = 1'b0; address0 = '0; wdata0 = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (ready !== 1'b0 || freeze !== 1'b0 || we_n !== 1'b1 || dq_oe !== 1'b0 ||
            sram_addr !== 18'd0 || dq_out !== 16'd0 || rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset rdy=%b frz=%b wen=%b oe=%b addr=%h dq=%h rdata=%h exp 0 0 1 0 0 0 0",
                     ready, freeze, we_n, dq_oe, sram_addr, dq_out, rdata);
        end
        rst = 1'b1;
        exp_rdata = '0;
        exp_last  = '0;
        idle(2);
    endtask

    task automatic test_directed;
        int lat;
        sram_mem[4] = 16'h5678; exp_mem[4] = 16'h5678;
        sram_mem[5] = 16'h1234; exp_mem[5] = 16'h1234;
        do_access(1'b0, 1'b0, 32'h0000_0008, 32'h0, 0, lat);
        checks++;
        if (lat != 7 || rdata !== 32'h1234_5678) begin
            errors++; $display("FAIL directed_read lat=%0d rdata=%h exp 7 12345678", lat, rdata);
        end
        idle(1);
        do_access(1'b1, 1'b0, 32'h0000_0010, 32'hCAFE_BABE, 1, lat);
        checks++;
        if (lat != 7 || sram_rd(18'd8) !== 16'hBABE || sram_rd(18'd9) !== 16'hCAFE) begin
            errors++; $display("FAIL directed_write lat=%0d mem8=%h mem9=%h exp 7 babe cafe",
                               lat, sram_rd(18'd8), sram_rd(18'd9));
        end
        idle(1);
    endtask

    task automatic test_both;
        int lat;
        do_access(1'b1, 1'b1, $urandom, $urandom, 0, lat);
        idle(1);
    endtask

    task automatic test_back_to_back;
        int lat, d1, d2;
        logic [31:0] a;
        a = $urandom;
        do_access(1'b0, 1'b0, a, 32'h0, 0, lat);
        d1 = cyc;
        do_access(1'b0, 1'b0, a, 32'h0, 0, lat);
        d2 = cyc;
        checks++;
        if (d2 - d1 != 8) begin
            errors++; $display("FAIL back_to_back spacing got %0d exp 8", d2 - d1);
        end
        idle(1);
    endtask

    task automatic test_random;
        int lat;
        logic [31:0] a;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            a[18:2] = 17'($urandom_range(0, 15));
            do_access(1'($urandom), ($urandom_range(0, 3) == 0), a, $urandom,
                      $urandom_range(0, 2), lat);
            idle($urandom_range(0, 2));
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        logic [31:0] a, wd;
        for (int op = 0; op < 2; op++) begin
            do_access(1'b0, 1'b0, $urandom, 32'h0, 1, lat);
            idle(1);
            a = $urandom; wd = $urandom;
            @(negedge clk);
            w_en = (op == 1); r_en = (op == 0); address = a; wdata = wd;
            repeat (W+3) @(negedge clk);
            rst = 1'b0; r_en = 1'b0; w_en = 1'b0;
            @(negedge clk);
            #1;
            checks++;
            if (ready !== 1'b0 || we_n !== 1'b1 || dq_oe !== 1'b0 || sram_addr !== 18'd0 ||
                rdata !== 32'd0) begin
                errors++;
                $display("FAIL reset_mid op=%0d rdy=%b wen=%b oe=%b addr=%h rdata=%h exp 0 1 0 0 0",
                         op, ready, we_n, dq_oe, sram_addr, rdata);
            end
            rst = 1'b1;
            exp_rdata = '0;
            exp_last  = '0;
            if (op == 1) begin
                exp_mem[int'({a[18:2], 1'b0})] = wd[15:0];
                exp_mem[int'({a[18:2], 1'b1})] = wd[31:16];
            end
            idle(6);
        end
    endtask

    task automatic test_wait0;
        logic [31:0] a, wd;
        logic [16:0] wa;
        bit exp_rdy, exp_wen;
        logic [17:0] exp_ad;
        for (int op = 0; op < 2; op++) begin
            a = $urandom; wd = $urandom; wa = a[18:2];
            @(negedge clk);
            r_en0 = (op == 0); w_en0 = (op == 1); address0 = a; wdata0 = wd;
            #1;
            checks++;
            if (ready0 !== 1'b0 || freeze0 !== 1'b1) begin
                errors++; $display("FAIL w0_sample rdy=%b frz=%b exp 0 1", ready0, freeze0);
            end
            for (int k = 1; k <= 3; k++) begin
                @(negedge clk);
                r_en0 = 1'b0; w_en0 = 1'b0;
                #1;
                exp_rdy = (k == 3);
                exp_wen = !(op == 1 && k <= 2);
                exp_ad  = (k == 1) ? {wa, 1'b0} : {wa, 1'b1};
                checks++;
                if (ready0 !== exp_rdy || we_n0 !== exp_wen || sram_addr0 !== exp_ad) begin
                    errors++;
                    $display("FAIL w0 op=%0d k=%0d rdy=%b wen=%b addr=%h exp %b %b %h",
                             op, k, ready0, we_n0, sram_addr0, exp_rdy, exp_wen, exp_ad);
                end
            end
            if (op == 0) begin
                checks++;
                if (rdata0 !== {dflt({wa, 1'b1}), dflt({wa, 1'b0})}) begin
                    errors++; $display("FAIL w0_rdata got %h exp %h", rdata0,
                                       {dflt({wa, 1'b1}), dflt({wa, 1'b0})});
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_both;
        test_back_to_back;
        test_random;
        test_reset_mid;
        test_wait0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
